// File: rtl/light_sequencer.sv
// Main/side-street traffic light sequencer: requests a phase length via Interval,
// loads the returned Value one cycle later and counts it down on the 1 Hz enable.
module light_sequencer (
  input  logic       clk,
  input  logic       Reset_N,
  input  logic       Second_Tick,
  input  logic       Sensor,
  input  logic       Walk_Request,
  input  logic       Restart,
  input  logic [3:0] Value,
  output logic [1:0] Interval,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk_Lamp,
  output logic       Phase_Done
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    SIDE_GREEN  = 3'd2,
    SIDE_EXT    = 3'd3,
    SIDE_YELLOW = 3'd4,
    WALK        = 3'd5
  } state_t;

  localparam logic [1:0] IV_BASE = 2'b00;
  localparam logic [1:0] IV_EXT  = 2'b01;
  localparam logic [1:0] IV_YEL  = 2'b10;

  state_t     state, state_n;
  logic [1:0] interval_n;
  logic       load_pending, load_pending_n;
  logic [3:0] count, count_n;
  logic       sensor_latch, sensor_latch_n;
  logic       walk_latch, walk_latch_n;
  logic       expire;

  function automatic logic [1:0] code_of(input state_t s);
    case (s)
      MAIN_YELLOW, SIDE_YELLOW: code_of = IV_YEL;
      SIDE_EXT, WALK:           code_of = IV_EXT;
      default:                  code_of = IV_BASE;
    endcase
  endfunction

  // Ticks are ignored during the load cycle so a phase lasts exactly Value ticks.
  assign expire     = Second_Tick && !load_pending && (count == 4'd1);
  assign Phase_Done = expire && !Restart;

  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state        <= MAIN_GREEN;
      Interval     <= IV_BASE;
      load_pending <= 1'b1;
      count        <= 4'd0;
      sensor_latch <= 1'b0;
      walk_latch   <= 1'b0;
    end else begin
      state        <= state_n;
      Interval     <= interval_n;
      load_pending <= load_pending_n;
      count        <= count_n;
      sensor_latch <= sensor_latch_n;
      walk_latch   <= walk_latch_n;
    end
  end

  always_comb begin
    state_n        = state;
    interval_n     = Interval;
    load_pending_n = load_pending;
    count_n        = count;
    sensor_latch_n = sensor_latch | ((state == MAIN_GREEN) && Sensor);
    walk_latch_n   = walk_latch | Walk_Request;

    if (Restart) begin
      state_n        = MAIN_GREEN;
      interval_n     = IV_BASE;
      load_pending_n = 1'b1;
      sensor_latch_n = 1'b0;
      walk_latch_n   = 1'b0;
    end else if (load_pending) begin
      count_n        = (Value == 4'd0) ? 4'd1 : Value;
      load_pending_n = 1'b0;
    end else if (expire) begin
      case (state)
        MAIN_GREEN:  state_n = sensor_latch ? MAIN_YELLOW : MAIN_GREEN;
        MAIN_YELLOW: state_n = SIDE_GREEN;
        SIDE_GREEN:  state_n = Sensor ? SIDE_EXT : SIDE_YELLOW;
        SIDE_EXT:    state_n = SIDE_YELLOW;
        SIDE_YELLOW: state_n = walk_latch ? WALK : MAIN_GREEN;
        WALK:        state_n = MAIN_GREEN;
        default:     state_n = MAIN_GREEN;
      endcase
      interval_n     = code_of(state_n);
      load_pending_n = 1'b1;
      if ((state == MAIN_GREEN) && (state_n != MAIN_GREEN)) sensor_latch_n = 1'b0;
      // Entry into WALK consumes the request; later presses wait for the next lap.
      if (state_n == WALK) walk_latch_n = 1'b0;
    end else if (Second_Tick && (count > 4'd1)) begin
      count_n = count - 4'd1;
    end
  end

  always_comb begin
    Main_Light = 3'b100;
    Side_Light = 3'b100;
    Walk_Lamp  = 1'b0;
    case (state)
      MAIN_GREEN:           Main_Light = 3'b001;
      MAIN_YELLOW:          Main_Light = 3'b010;
      SIDE_GREEN, SIDE_EXT: Side_Light = 3'b001;
      SIDE_YELLOW:          Side_Light = 3'b010;
      WALK:                 Walk_Lamp  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: directed scenarios then random traffic, all checked
// each cycle against a phase-level reference model.
module tb_light_sequencer;
  logic       clk = 1'b0;
  logic       Reset_N = 1'b0;
  logic       Second_Tick = 1'b0, Sensor = 1'b0, Walk_Request = 1'b0, Restart = 1'b0;
  logic [3:0] Value;
  logic [1:0] Interval;
  logic [2:0] Main_Light, Side_Light;
  logic       Walk_Lamp, Phase_Done;

  logic [3:0] tbl [4];
  always_comb Value = tbl[Interval];

  always #5 clk = ~clk;

  light_sequencer dut (
    .clk(clk), .Reset_N(Reset_N), .Second_Tick(Second_Tick), .Sensor(Sensor),
    .Walk_Request(Walk_Request), .Restart(Restart), .Value(Value),
    .Interval(Interval), .Main_Light(Main_Light), .Side_Light(Side_Light),
    .Walk_Lamp(Walk_Lamp), .Phase_Done(Phase_Done)
  );

  // Phase-level model: phase id, seconds left, and whether the length is still to be fetched.
  localparam int MG = 0, MY = 1, SG = 2, SX = 3, SY = 4, WK = 5;
  int         pcode [6] = '{0, 2, 0, 1, 2, 1};
  logic [2:0] mlut  [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] slut  [6] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100};
  int m_ph, m_left;
  bit m_fresh, m_sl, m_wl;

  int tests = 0, fails = 0;
  int tcnt = 0, nticks = 0;
  bit rmode = 0, obs_pd;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = MG; m_left = 0; m_fresh = 1; m_sl = 0; m_wl = 0;
  endtask

  task automatic model_step();
    bit sl0, wl0;
    int nx, len;
    sl0 = m_sl; wl0 = m_wl;
    if (Restart) begin
      m_ph = MG; m_fresh = 1; m_sl = 0; m_wl = 0;
    end else begin
      if (m_ph == MG && Sensor) m_sl = 1;
      if (Walk_Request) m_wl = 1;
      if (m_fresh) begin
        len = int'(tbl[pcode[m_ph]]);
        m_left = (len == 0) ? 1 : len;
        m_fresh = 0;
      end else if (Second_Tick) begin
        if (m_left > 1) m_left--;
        else begin
          case (m_ph)
            MG:      nx = sl0 ? MY : MG;
            MY:      nx = SG;
            SG:      nx = Sensor ? SX : SY;
            SX:      nx = SY;
            SY:      nx = wl0 ? WK : MG;
            default: nx = MG;
          endcase
          if (m_ph == MG && nx != MG) m_sl = 0;
          if (nx == WK) m_wl = 0;
          m_ph = nx; m_fresh = 1;
        end
      end
    end
  endtask

  // One clock: pick tick, check outputs mid-low-phase, advance model on the edge.
  task automatic cyc();
    bit exp_pd;
    if (rmode) Second_Tick = ($urandom_range(0, 3) == 0);
    else       Second_Tick = (tcnt % 10 == 9);
    #1;
    exp_pd = Second_Tick && !m_fresh && m_left == 1 && !Restart;
    obs_pd = Phase_Done;
    chk("main", Main_Light, mlut[m_ph]);
    chk("side", Side_Light, slut[m_ph]);
    chk("walk_lamp", Walk_Lamp, (m_ph == WK));
    chk("interval", Interval, pcode[m_ph]);
    chk("phase_done", Phase_Done, exp_pd);
    @(posedge clk);
    model_step();
    if (Second_Tick) nticks++;
    tcnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    Second_Tick = 0; Restart = 0; Walk_Request = 0;
    #2 Reset_N = 1'b0;
    #1;
    model_reset();
    chk("rst_main", Main_Light, 3'b001);
    chk("rst_side", Side_Light, 3'b100);
    chk("rst_walk", Walk_Lamp, 1'b0);
    chk("rst_iv", Interval, 2'b00);
    chk("rst_pd", Phase_Done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    Reset_N = 1'b1;
    tcnt = 0; nticks = 0;
  endtask

  task automatic run_until(input int ph, input string tag);
    int n = 0;
    while (m_ph != ph && n < 600) begin cyc(); n++; end
    if (m_ph != ph) begin
      tests++; fails++;
      $display("FAIL %s: phase %0d not reached, at %0d", tag, ph, m_ph);
    end
  endtask

  task automatic ticks_to_pd(output int t);
    int n = 0, base = nticks;
    t = -1;
    while (n < 200) begin
      cyc(); n++;
      if (obs_pd) begin t = nticks - base; break; end
    end
  endtask

  initial begin
    int pd_ticks [$];
    logic [1:0] iv_log [$];
    int t, ym, ys;
    tbl[0] = 4'd6; tbl[1] = 4'd3; tbl[2] = 4'd2; tbl[3] = 4'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle main street: re-entry every 6 ticks.
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (obs_pd) pd_ticks.push_back(nticks);
    end
    chk("idle_pd_count", pd_ticks.size(), 3);
    if (pd_ticks.size() == 3) begin
      chk("idle_pd0", pd_ticks[0], 6);
      chk("idle_pd1", pd_ticks[1], 12);
      chk("idle_pd2", pd_ticks[2], 18);
    end

    // One-cycle sensor pulse drives a full side cycle.
    iv_log.push_back(Interval);
    Sensor = 1; cyc(); Sensor = 0;
    for (int i = 0; i < 160; i++) begin
      cyc();
      if (Interval != iv_log[$]) iv_log.push_back(Interval);
    end
    chk("iv_seq_len", iv_log.size(), 5);
    if (iv_log.size() == 5) begin
      chk("iv_seq1", iv_log[1], 2'b10);
      chk("iv_seq2", iv_log[2], 2'b00);
      chk("iv_seq3", iv_log[3], 2'b10);
      chk("iv_seq4", iv_log[4], 2'b00);
    end

    // Sensor held, walk pressed in side green: extension then walk.
    Sensor = 1;
    run_until(SG, "reach_sg");
    Walk_Request = 1; cyc(); Walk_Request = 0;
    run_until(WK, "reach_walk");
    chk("walk_lamp_on", Walk_Lamp, 1'b1);
    chk("walk_main", Main_Light, 3'b100);
    chk("walk_side", Side_Light, 3'b100);

    // Reset during walk, then a plain 6-tick main green.
    Sensor = 0;
    do_reset();
    ticks_to_pd(t);
    chk("post_reset_len", t, 6);
    chk("post_reset_main", Main_Light, 3'b001);

    // Restart mid side extension picks up the new base length.
    Sensor = 1;
    run_until(SX, "reach_sx");
    repeat (12) cyc();
    tbl[0] = 4'd5; Sensor = 0; Restart = 1;
    cyc();
    Restart = 0;
    chk("restart_main", Main_Light, 3'b001);
    chk("restart_iv", Interval, 2'b00);
    ticks_to_pd(t);
    chk("restart_len", t, 5);
    chk("restart_stay_mg", Main_Light, 3'b001);

    // Zero yellow length is clamped to one tick.
    tbl[0] = 4'd6; tbl[2] = 4'd0;
    Sensor = 1; cyc(); Sensor = 0;
    ym = 0; ys = 0;
    for (int i = 0; i < 220; i++) begin
      cyc();
      if (Main_Light == 3'b010) ym++;
      if (Side_Light == 3'b010) ys++;
    end
    chk("yel0_main_cycles", ym, 10);
    chk("yel0_side_cycles", ys, 10);

    // Random traffic against the model.
    rmode = 1;
    for (int i = 0; i < 4000; i++) begin
      Sensor = ($urandom_range(0, 2) == 0);
      Walk_Request = ($urandom_range(0, 15) == 0);
      Restart = ($urandom_range(0, 80) == 0);
      if ($urandom_range(0, 50) == 0) tbl[$urandom_range(0, 2)] = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
